uart_rx_parity: RTL

UART receiver that deserialises the asynchronous rx line into bytes and checks the received parity bit. It computes expected parity as the XOR-reduction of the data byte, the same rule our transmit-side parity generator uses. It sits between the pad-level rx input and the byte-consumer logic and flags parity and framing errors alongside each byte.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 34 +++
 rtl/uart_rx_parity.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// parity rule used by both the receive checker and the transmit generator.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  // Even parity is the XOR-reduction of the data; odd parity is its inverse.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every DIV clocks,
// DIV = CLK_FREQ / (BAUD * OVERSAMPLE), never less than 1.
module uart_baud_tick #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divide the system clock down to the oversample rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver with optional parity check. Deserialises the asynchronous
// rx line LSB first, then flags parity and framing errors alongside each
// delivered byte. A low stop bit parks the receiver until the line idles.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_EN   = (PARITY_EN != 0);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  logic                 tick;
  logic                 rx_s1;
  logic                 rx_s2;
  logic                 rx_q;
  logic                 mid_bit;
  state_t               state;
  logic [OS_W-1:0]      os_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Two-flop synchroniser plus one delayed copy for falling-edge detection;
  // all reset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  // Sample point: the oversample tick that lands in the middle of a bit.
  always_comb begin
    mid_bit = tick && (os_cnt == OS_MID);
  end

  // Frame state machine with registered byte, flags, valid pulse and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      // The in-bit counter wraps every OVERSAMPLE ticks, so once aligned to
      // the start edge it stays aligned for every following bit.
      if (state != IDLE && tick) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (rx_q && !rx_s2) begin
            os_cnt <= '0;
            state  <= START;
          end
        end

        START: begin
          if (mid_bit) begin
            if (!rx_s2) begin
              bit_idx <= '0;
              busy    <= 1'b1;
              state   <= DATA;
            end else begin
              state <= IDLE;
            end
          end
        end

        DATA: begin
          if (mid_bit) begin
            shift[bit_idx] <= rx_s2;
            if (bit_idx == IDX_LAST) begin
              state <= PAR_EN ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        PARITY: begin
          if (mid_bit) begin
            par_bit <= rx_s2;
            state   <= STOP;
          end
        end

        STOP: begin
          if (mid_bit) begin
            rx_data    <= shift;
            parity_err <= PAR_EN && (par_bit != calc_parity(shift, PAR_ODD));
            frame_err  <= !rx_s2;
            rx_valid   <= 1'b1;
            if (rx_s2) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= BREAK;
            end
          end
        end

        BREAK: begin
          if (rx_s2) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
